// File: rtl/i_sram_pkg.sv
// Shared constants and fill-state encoding for the instruction SRAM fill/fetch controller.
package i_sram_pkg;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 200;
  localparam int LINE_W = 240;
  localparam int BEAT_W = 16;
  localparam int BEATS  = 15;
  localparam int CNT_W  = 4;

  localparam logic [ADDR_W-1:0] DEPTH_A   = 8'd200;
  localparam logic [CNT_W-1:0]  LAST_BEAT = 4'd14;

  typedef enum logic [1:0] {
    FILL_IDLE    = 2'd0,
    FILL_COLLECT = 2'd1,
    FILL_WRITE   = 2'd2
  } fillState_e;

  function automatic logic addrInRange(input logic [ADDR_W-1:0] addr);
    return addr < DEPTH_A;
  endfunction

endpackage

// File: rtl/i_sram_fetch_port.sv
// One fetch requester: hazard-gated accept, registered read address, rvalid/err generation.
module i_sram_fetch_port
  import i_sram_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              reqValid,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic              fillBusy,
  input  logic [ADDR_W-1:0] fillAddr,
  input  logic              lineValid,
  output logic              reqReady,
  output logic              respValid,
  output logic              respErr,
  output logic [ADDR_W-1:0] readAddr
);

  logic accept;

  // Hold off only the line currently being assembled or written.
  always_comb begin
    reqReady = 1'b1;
    if (fillBusy && (reqAddr == fillAddr)) begin
      reqReady = 1'b0;
    end else begin
      reqReady = 1'b1;
    end
    accept = reqValid & reqReady;
  end

  // Response qualifiers and SRAM read address, one cycle after accept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      respValid <= 1'b0;
      respErr   <= 1'b0;
      readAddr  <= '0;
    end else if (accept) begin
      respValid <= 1'b1;
      respErr   <= !lineValid || !addrInRange(reqAddr);
      readAddr  <= reqAddr;
    end else begin
      respValid <= 1'b0;
      respErr   <= 1'b0;
    end
  end

endmodule

// File: rtl/i_sram_fill_ctrl.sv
// Instruction SRAM controller: assembles 16-bit beats into 240-bit lines, owns the write
// port, tracks per-line validity and serves two independent fetch ports.
module i_sram_fill_ctrl
  import i_sram_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic              fill_valid,
  input  logic [BEAT_W-1:0] fill_data,
  output logic              fill_ready,
  output logic              fill_done,
  output logic              fill_err,
  input  logic              fetch0_valid,
  input  logic [ADDR_W-1:0] fetch0_addr,
  output logic              fetch0_ready,
  output logic              fetch0_rvalid,
  output logic [LINE_W-1:0] fetch0_data,
  output logic              fetch0_err,
  input  logic              fetch1_valid,
  input  logic [ADDR_W-1:0] fetch1_addr,
  output logic              fetch1_ready,
  output logic              fetch1_rvalid,
  output logic [LINE_W-1:0] fetch1_data,
  output logic              fetch1_err,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_waddr,
  output logic [LINE_W-1:0] sram_wdata,
  output logic [ADDR_W-1:0] sram_raddr1,
  output logic [ADDR_W-1:0] sram_raddr2,
  input  logic [LINE_W-1:0] sram_rdata1,
  input  logic [LINE_W-1:0] sram_rdata2
);

  fillState_e        fillState;
  logic [ADDR_W-1:0] fillAddrQ;
  logic [CNT_W-1:0]  beatCnt;
  logic [LINE_W-1:0] lineBuf;
  logic [LINE_W-1:0] nextLine;
  logic [7:0]        beatBase;
  logic [DEPTH-1:0]  lineValid;
  logic              fillBusy;
  logic              beatAccept;
  logic              lineValid0;
  logic              lineValid1;

  // Line buffer with the current beat merged in, so the final beat goes straight to the write bus.
  always_comb begin
    fillBusy   = (fillState != FILL_IDLE);
    beatAccept = fill_valid & fill_ready;
    beatBase   = 8'(beatCnt) * 8'(BEAT_W);
    nextLine   = lineBuf;
    nextLine[beatBase +: BEAT_W] = fill_data;
  end

  // Validity lookup is guarded so out-of-range addresses never index the bitmap.
  always_comb begin
    lineValid0 = 1'b0;
    lineValid1 = 1'b0;
    if (addrInRange(fetch0_addr)) begin
      lineValid0 = lineValid[fetch0_addr];
    end else begin
      lineValid0 = 1'b0;
    end
    if (addrInRange(fetch1_addr)) begin
      lineValid1 = lineValid[fetch1_addr];
    end else begin
      lineValid1 = 1'b0;
    end
  end

  // Fill sequencer: IDLE -> COLLECT (15 beats) -> WRITE (one SRAM write) -> IDLE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fillState  <= FILL_IDLE;
      fillAddrQ  <= '0;
      beatCnt    <= '0;
      lineBuf    <= '0;
      lineValid  <= '0;
      fill_ready <= 1'b0;
      fill_done  <= 1'b0;
      fill_err   <= 1'b0;
      sram_we    <= 1'b0;
      sram_waddr <= '0;
      sram_wdata <= '0;
    end else begin
      fill_done <= 1'b0;
      fill_err  <= 1'b0;
      sram_we   <= 1'b0;
      case (fillState)
        FILL_IDLE: begin
          if (fill_start && addrInRange(fill_addr)) begin
            fillAddrQ  <= fill_addr;
            beatCnt    <= '0;
            fill_ready <= 1'b1;
            fillState  <= FILL_COLLECT;
          end else if (fill_start) begin
            fill_err <= 1'b1;
          end
        end
        FILL_COLLECT: begin
          if (beatAccept) begin
            lineBuf <= nextLine;
            if (beatCnt == LAST_BEAT) begin
              fill_ready <= 1'b0;
              sram_we    <= 1'b1;
              sram_waddr <= fillAddrQ;
              sram_wdata <= nextLine;
              fillState  <= FILL_WRITE;
            end else begin
              beatCnt <= beatCnt + 4'd1;
            end
          end
        end
        FILL_WRITE: begin
          lineValid[fillAddrQ] <= 1'b1;
          fill_done            <= 1'b1;
          fillState            <= FILL_IDLE;
        end
        default: begin
          fill_ready <= 1'b0;
          fillState  <= FILL_IDLE;
        end
      endcase
    end
  end

  i_sram_fetch_port uFetch0 (
    .clock     (clock),
    .reset_n   (reset_n),
    .reqValid  (fetch0_valid),
    .reqAddr   (fetch0_addr),
    .fillBusy  (fillBusy),
    .fillAddr  (fillAddrQ),
    .lineValid (lineValid0),
    .reqReady  (fetch0_ready),
    .respValid (fetch0_rvalid),
    .respErr   (fetch0_err),
    .readAddr  (sram_raddr1)
  );

  i_sram_fetch_port uFetch1 (
    .clock     (clock),
    .reset_n   (reset_n),
    .reqValid  (fetch1_valid),
    .reqAddr   (fetch1_addr),
    .fillBusy  (fillBusy),
    .fillAddr  (fillAddrQ),
    .lineValid (lineValid1),
    .reqReady  (fetch1_ready),
    .respValid (fetch1_rvalid),
    .respErr   (fetch1_err),
    .readAddr  (sram_raddr2)
  );

  assign fetch0_data = sram_rdata1;
  assign fetch1_data = sram_rdata2;

endmodule

// File: doc/i_sram_fill_ctrl.md
# i_sram_fill_ctrl

Controller that sequences the 240-bit-wide instruction SRAM (200 lines, 1 write port, 2 read ports). It assembles lines from a 16-bit fill stream, owns the single write port, and serves two independent fetch requesters on the two read ports. It tracks per-line valid state and holds off fetches that would race an in-flight line write. It sits between the program loader and the fetch stage(s), directly in front of `i_sram`.

## Interface
- `ADDR_W`, 8: SRAM line-address width.
- `DEPTH`, 200: number of SRAM lines.
- `LINE_W`, 240: line width.
- `BEAT_W`, 16: fill beat width.
- `BEATS`, 15: beats per line; must equal LINE_W/BEAT_W.

Ports:
- `clock`  in  1  single clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `fill_start`  in  1  request to fill line `fill_addr`; sampled in IDLE only.
- `fill_addr`  in  ADDR_W  target line.
- `fill_valid`  in  1  beat valid.
- `fill_data`  in  BEAT_W  beat payload.
- `fill_ready`  out  1  beat accepted when `fill_valid & fill_ready`.
- `fill_done`  out  1  one-cycle pulse; line written.
- `fill_err`  out  1  one-cycle pulse; `fill_addr >= DEPTH`.
- `fetchK_valid`, K=0,1  in  1  fetch request.
- `fetchK_addr`  in  ADDR_W  requested line.
- `fetchK_ready`  out  1  request accepted when `valid & ready`.
- `fetchK_rvalid`  out  1  response valid.
- `fetchK_data`  out  LINE_W  line data.
- `fetchK_err`  out  1  qualifies rvalid; line not valid or address out of range.
- `sram_we`  out  1  to SRAM WE.
- `sram_waddr`  out  ADDR_W  SRAM write address.
- `sram_wdata`  out  LINE_W  SRAM write data.
- `sram_raddr1`, `sram_raddr2`  out  ADDR_W  SRAM read addresses (fetch0, fetch1).
- `sram_rdata1`, `sram_rdata2`  in  LINE_W  SRAM read data.

## Operation
- Fill FSM states are IDLE, COLLECT and WRITE.
  - IDLE: when `fill_start` is high and `fill_addr < DEPTH`, latch the address, clear the beat counter, go to COLLECT. When `fill_start` is high and `fill_addr >= DEPTH`, pulse `fill_err` and stay in IDLE.
  - COLLECT: `fill_ready` = 1. Each accepted beat n (0..14) is written into line buffer bits [16n+15:16n]. Acceptance of beat 14 moves the FSM to WRITE.
  - WRITE: `sram_we` = 1 for exactly one cycle, with the latched address and the buffer on the write bus. At the end of the cycle, set `valid[addr]`, pulse `fill_done` in the following cycle, and return to IDLE.
  - `fill_start` is ignored outside IDLE.
- Valid bitmap: DEPTH bits, all cleared by reset. Refilling an already-valid line keeps it valid.
- Fetch port K, independent of the other port:
  - `fetchK_ready` = 0 when the FSM is in COLLECT or WRITE and `fetchK_addr` equals the latched fill address. Otherwise it is 1.
  - On accept, register the address onto `sram_raddrK` and set `rvalid` in the next cycle. `data` is `sram_rdataK` passed through. `err` = !valid[addr] or addr >= DEPTH, registered at accept.
  - Both ports may accept in the same cycle, including to the same line.
- All SRAM-side outputs are registered (SRAM adds 1 ns in/out delay).

## Timing
- Reset values:
  - FSM = IDLE.
  - `fill_ready`, `fill_done`, `fill_err`, `sram_we` = 0.
  - `sram_waddr`, `sram_wdata`, `sram_raddr1/2` = 0.
  - `fetchK_rvalid`, `fetchK_err` = 0.
  - Valid bitmap cleared.
- Fetch latency: accept at edge N gives `rvalid` high during cycle N+1, one cycle per accept. Throughput is 1 per cycle per port.
- Fill: minimum 17 cycles per line (1 IDLE + 15 beats + 1 WRITE). Gaps in `fill_valid` stretch COLLECT.
- Stalled fetch: `ready` returns the cycle after WRITE. The read in that cycle sees the new data.
- Reset asserted mid-fill discards the buffer, writes nothing, and sets no valid bit.

## Structure
- Shared package `i_sram_pkg`: ADDR_W, DEPTH, LINE_W, BEAT_W, BEATS constants; fill-state enum.
- One sub-module, `i_sram_fetch_port`, instantiated twice. It contains the accept/hazard compare, the address register, and rvalid/err generation.

## Test plan
- Reset, fill line 5 with beats 0x0000..0x000E, fetch0 line 5:
  - `sram_we` is high exactly one cycle with `waddr` = 5 and `wdata[15:0]` = 0, `wdata[239:224]` = 0x000E.
  - `fill_done` pulses.
  - `fetch0_data` matches the written line with err = 0, one cycle after accept.
- After reset, fetch1 line 7 (never filled): `rvalid` = 1 with `fetch1_err` = 1. Fetch line 200: err = 1.
- `fill_start` with `fill_addr` = 200: `fill_err` pulses, FSM stays IDLE, `fill_ready` stays 0.
- Fill line 9 while fetch0 repeatedly requests 9 and fetch1 requests 3:
  - `fetch0_ready` = 0 through COLLECT and WRITE, returns the cycle after WRITE, and the data is new.
  - fetch1 is served every cycle.
- `fill_valid` toggles every other cycle: 15 beats are still assembled in order and the write occurs once.
- `reset_n` is dropped after beat 7 of a fill to line 2, then line 2 is fetched: err = 1 and no `sram_we` pulse is seen.
